// File: rtl/rob_commit_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rob_commit_queue                                            |
// | Description : Circular reorder queue between issue and commit; optional  |
// |               zero-latency write-back bypass under ROB_WB_BYPASS_EN.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package rob_commit_queue_pkg;
  localparam int XLEN          = 64;
  localparam int TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [6:0]               op;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;
endpackage

module rob_commit_queue
  import rob_commit_queue_pkg::*;
#(
  parameter int NR_ENTRIES      = 8,
  parameter int NR_WB_PORTS     = 4,
  parameter int NR_COMMIT_PORTS = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  scoreboard_entry_t                            issue_instr_i,
  input  logic                                         issue_valid_i,
  output logic                                         issue_ack_o,
  output logic [TRANS_ID_BITS-1:0]                     issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]    wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][XLEN-1:0]             wb_data_i,
  input  exception_t [NR_WB_PORTS-1:0]                 wb_ex_i,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]      commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
  output logic                                         empty_o
);

  localparam int c_cnt_w = $clog2(NR_ENTRIES + 1);
  localparam int c_pop_w = $clog2(NR_COMMIT_PORTS + 1);
  localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(NR_ENTRIES);

  if (NR_ENTRIES != 2 ** TRANS_ID_BITS || NR_COMMIT_PORTS > NR_ENTRIES) begin : g_bad_cfg
    $error("rob_commit_queue: unsupported parameter combination");
  end

  logic [NR_ENTRIES-1:0]                  r_busy;
  logic [NR_ENTRIES-1:0]                  r_done;
  scoreboard_entry_t [NR_ENTRIES-1:0]     r_slot;
  logic [TRANS_ID_BITS-1:0]               r_issue_ptr;
  logic [TRANS_ID_BITS-1:0]               r_commit_ptr;
  logic [c_cnt_w-1:0]                     r_count;

  logic                                   w_issue_ack;
  scoreboard_entry_t                      w_alloc;
  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] w_commit;
  logic [NR_COMMIT_PORTS-1:0]             w_honoured;
  logic [c_pop_w-1:0]                     w_pop_cnt;

  // Full-queue check uses the current count, so a same-cycle pop never frees a slot.
  assign w_issue_ack      = issue_valid_i && (r_count < c_full) && !flush_i;
  assign issue_ack_o      = w_issue_ack;
  assign issue_trans_id_o = r_issue_ptr;
  assign empty_o          = (r_count == '0);
  assign commit_instr_o   = w_commit;

  always_comb begin
    w_alloc          = issue_instr_i;
    w_alloc.valid    = 1'b0;
    w_alloc.ex.valid = 1'b0;
    w_alloc.trans_id = r_issue_ptr;
  end

  always_comb begin
    logic [TRANS_ID_BITS-1:0] w_idx;
    w_commit = '0;
    w_idx    = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_idx             = r_commit_ptr + TRANS_ID_BITS'(i);
      w_commit[i]       = r_slot[w_idx];
      w_commit[i].valid = r_busy[w_idx] && r_done[w_idx] && (r_count > c_cnt_w'(i));
`ifdef ROB_WB_BYPASS_EN
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && (wb_trans_id_i[p] == w_idx) && r_busy[w_idx] &&
            (r_count > c_cnt_w'(i))) begin
          w_commit[i].result = wb_data_i[p];
          if (wb_ex_i[p].valid) w_commit[i].ex = wb_ex_i[p];
          w_commit[i].valid  = 1'b1;
        end
      end
`endif
    end
  end

  // Only an unbroken prefix of acks on valid ports retires.
  always_comb begin
    logic w_run;
    w_run      = 1'b1;
    w_honoured = '0;
    w_pop_cnt  = '0;
    for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
      w_run         = w_run && commit_ack_i[i] && w_commit[i].valid;
      w_honoured[i] = w_run;
      if (w_run) w_pop_cnt = w_pop_cnt + c_pop_w'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy       <= '0;
      r_done       <= '0;
      r_issue_ptr  <= '0;
      r_commit_ptr <= '0;
      r_count      <= '0;
    end else if (flush_i) begin
      r_busy       <= '0;
      r_done       <= '0;
      r_issue_ptr  <= '0;
      r_commit_ptr <= '0;
      r_count      <= '0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && r_busy[wb_trans_id_i[p]]) r_done[wb_trans_id_i[p]] <= 1'b1;
      end
      for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (w_honoured[i]) begin
          r_busy[r_commit_ptr + TRANS_ID_BITS'(i)] <= 1'b0;
          r_done[r_commit_ptr + TRANS_ID_BITS'(i)] <= 1'b0;
        end
      end
      if (w_issue_ack) begin
        r_busy[r_issue_ptr] <= 1'b1;
        r_done[r_issue_ptr] <= 1'b0;
        r_issue_ptr         <= r_issue_ptr + 1'b1;
      end
      r_commit_ptr <= r_commit_ptr + TRANS_ID_BITS'(w_pop_cnt);
      r_count      <= r_count + c_cnt_w'(w_issue_ack) - c_cnt_w'(w_pop_cnt);
    end
  end

  // Payload storage needs no reset: visibility is governed entirely by busy/done.
  always_ff @(posedge clk_i) begin
    if (!flush_i) begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && r_busy[wb_trans_id_i[p]]) begin
          r_slot[wb_trans_id_i[p]].result <= wb_data_i[p];
          if (wb_ex_i[p].valid) r_slot[wb_trans_id_i[p]].ex <= wb_ex_i[p];
        end
      end
      if (w_issue_ack) r_slot[r_issue_ptr] <= w_alloc;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert ((commit_ack_i & ~w_honoured) == '0)
        else $warning("rob_commit_queue: non-prefix or invalid commit ack ignored");
    end
  end
`endif

endmodule
`default_nettype wire
